// File: rtl/draw_scheduler.sv
// Draw scheduler: generates the frame tick, runs each drawing client in turn
// once per frame, and forwards only the granted client's pixel writes to the
// VGA adapter. A per-client watchdog keeps a hung drawer from stalling a frame.
module draw_scheduler #(
    parameter int unsigned FRAME_CYCLES = 833333,
    parameter int unsigned NUM_CLIENTS  = 3,
    parameter int unsigned TIMEOUT      = 4096
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic        clear_flags,
    input  logic [2:0]  cli_plot,
    input  logic [23:0] cli_x,
    input  logic [23:0] cli_y,
    input  logic [8:0]  cli_colour,
    input  logic [2:0]  cli_done,
    output logic [2:0]  cli_start,
    output logic [7:0]  out_x,
    output logic [7:0]  out_y,
    output logic [2:0]  colour,
    output logic        plot,
    output logic        frame_tick,
    output logic        busy,
    output logic        overrun,
    output logic [2:0]  timeout_flags
);

    localparam int unsigned FrameW = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
    localparam int unsigned TimeW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [FrameW-1:0] FrameLast = FrameW'(FRAME_CYCLES - 1);
    localparam logic [TimeW-1:0]  TimeLast  = TimeW'(TIMEOUT - 1);
    localparam logic [1:0]        LastIdx   = 2'(NUM_CLIENTS - 1);

    typedef enum logic [1:0] {
        StWaitFrame,
        StStart,
        StRun
    } state_e;

    state_e            state_q, state_d;
    logic [1:0]        idx_q, idx_d;
    logic [TimeW-1:0]  tcnt_q, tcnt_d;
    logic [FrameW-1:0] frame_cnt_q;
    logic [2:0]        timeout_set;

    logic              sel_plot;
    logic              sel_done;
    logic [7:0]        sel_x;
    logic [7:0]        sel_y;
    logic [2:0]        sel_colour;

    // Free-running frame counter; the tick is registered one cycle after the last count.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            frame_cnt_q <= '0;
            frame_tick  <= 1'b0;
        end else begin
            frame_tick <= (frame_cnt_q == FrameLast);
            if (frame_cnt_q == FrameLast) begin
                frame_cnt_q <= '0;
            end else begin
                frame_cnt_q <= frame_cnt_q + 1'b1;
            end
        end
    end

    // Select the granted client's fields.
    always_comb begin
        sel_plot   = cli_plot[0];
        sel_done   = cli_done[0];
        sel_x      = cli_x[7:0];
        sel_y      = cli_y[7:0];
        sel_colour = cli_colour[2:0];
        case (idx_q)
            2'd1: begin
                sel_plot   = cli_plot[1];
                sel_done   = cli_done[1];
                sel_x      = cli_x[15:8];
                sel_y      = cli_y[15:8];
                sel_colour = cli_colour[5:3];
            end
            2'd2: begin
                sel_plot   = cli_plot[2];
                sel_done   = cli_done[2];
                sel_x      = cli_x[23:16];
                sel_y      = cli_y[23:16];
                sel_colour = cli_colour[8:6];
            end
            default: ;
        endcase
    end

    // Pass sequencer: next state, start pulses, busy and watchdog.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        tcnt_d      = tcnt_q;
        cli_start   = 3'b000;
        busy        = 1'b0;
        timeout_set = 3'b000;
        unique case (state_q)
            StWaitFrame: begin
                if (frame_tick && enable) begin
                    idx_d   = 2'd0;
                    state_d = StStart;
                end
            end
            StStart: begin
                cli_start = 3'b001 << idx_q;
                busy      = 1'b1;
                tcnt_d    = '0;
                state_d   = StRun;
            end
            StRun: begin
                busy   = 1'b1;
                tcnt_d = tcnt_q + 1'b1;
                // Done takes priority over a coincident timeout.
                if (sel_done || (tcnt_q == TimeLast)) begin
                    if (!sel_done) begin
                        timeout_set = 3'b001 << idx_q;
                    end
                    if (idx_q == LastIdx) begin
                        state_d = StWaitFrame;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = StStart;
                    end
                end
            end
            default: state_d = StWaitFrame;
        endcase
    end

    // Sequencer state registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StWaitFrame;
            idx_q   <= 2'd0;
            tcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            tcnt_q  <= tcnt_d;
        end
    end

    // Registered pixel port; only the granted client's writes pass, only in RUN.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_x  <= 8'd0;
            out_y  <= 8'd0;
            colour <= 3'd0;
            plot   <= 1'b0;
        end else begin
            plot <= (state_q == StRun) && sel_plot;
            if ((state_q == StRun) && sel_plot) begin
                out_x  <= sel_x;
                out_y  <= sel_y;
                colour <= sel_colour;
            end
        end
    end

    // Sticky flags; a set event in the same cycle as clear_flags wins.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            overrun       <= 1'b0;
            timeout_flags <= 3'b000;
        end else begin
            overrun       <= (overrun & ~clear_flags) | (frame_tick & busy);
            timeout_flags <= (timeout_flags & ~{3{clear_flags}}) | timeout_set;
        end
    end

endmodule

// File: tb/tb_draw_scheduler.sv
// Self-checking bench for draw_scheduler. A behavioural client model answers
// start pulses and pushes every pixel it drives into a scoreboard; a monitor
// pops and compares each forwarded write. A second instance with a long
// watchdog exercises the overrun path.
module tb_draw_scheduler;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic        clear_flags;
    logic [2:0]  cli_plot;
    logic [23:0] cli_x;
    logic [23:0] cli_y;
    logic [8:0]  cli_colour;
    logic [2:0]  cli_done;
    logic [2:0]  cli_start;
    logic [7:0]  out_x;
    logic [7:0]  out_y;
    logic [2:0]  colour;
    logic        plot;
    logic        frame_tick;
    logic        busy;
    logic        overrun;
    logic [2:0]  timeout_flags;

    // Overrun instance signals.
    logic        o_enable;
    logic        o_clear;
    logic [2:0]  o_done;
    logic [2:0]  o_start;
    logic [7:0]  o_x;
    logic [7:0]  o_y;
    logic [2:0]  o_col;
    logic        o_plot;
    logic        o_tick;
    logic        o_busy;
    logic        o_overrun;
    logic [2:0]  o_tflags;

    typedef struct packed {
        logic [7:0]  x;
        logic [7:0]  y;
        logic [2:0]  c;
        logic [31:0] cyc;
    } pix_t;

    pix_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_writes = 0;
    int   cyc      = 0;
    int   rel_cyc  = 0;
    bit   rogue_seen = 1'b0;
    int   cfg_npix [3];
    bit   cfg_hang [3];
    bit   rogue_en = 1'b0;

    draw_scheduler #(
        .FRAME_CYCLES(100),
        .NUM_CLIENTS (3),
        .TIMEOUT     (16)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .enable       (enable),
        .clear_flags  (clear_flags),
        .cli_plot     (cli_plot),
        .cli_x        (cli_x),
        .cli_y        (cli_y),
        .cli_colour   (cli_colour),
        .cli_done     (cli_done),
        .cli_start    (cli_start),
        .out_x        (out_x),
        .out_y        (out_y),
        .colour       (colour),
        .plot         (plot),
        .frame_tick   (frame_tick),
        .busy         (busy),
        .overrun      (overrun),
        .timeout_flags(timeout_flags)
    );

    draw_scheduler #(
        .FRAME_CYCLES(100),
        .NUM_CLIENTS (3),
        .TIMEOUT     (256)
    ) dut_ovr (
        .clock        (clock),
        .reset        (reset),
        .enable       (o_enable),
        .clear_flags  (o_clear),
        .cli_plot     (3'b000),
        .cli_x        (24'd0),
        .cli_y        (24'd0),
        .cli_colour   (9'd0),
        .cli_done     (o_done),
        .cli_start    (o_start),
        .out_x        (o_x),
        .out_y        (o_y),
        .colour       (o_col),
        .plot         (o_plot),
        .frame_tick   (o_tick),
        .busy         (o_busy),
        .overrun      (o_overrun),
        .timeout_flags(o_tflags)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required finish earlier");
        $fatal(1, "watchdog");
    end

    task automatic clear_cli();
        cli_plot   = '0;
        cli_x      = '0;
        cli_y      = '0;
        cli_colour = '0;
        cli_done   = '0;
    endtask

    // Behaviour of client k for one grant.
    task automatic serve(input int k);
        pix_t p;
        for (int i = 0; i < cfg_npix[k]; i++) begin
            @(negedge clock);
            if (reset === 1'b1) begin
                clear_cli();
                return;
            end
            cli_x[8*k +: 8]      = 8'(10 * k + i);
            cli_y[8*k +: 8]      = 8'd5;
            cli_colour[3*k +: 3] = 3'(k + 1);
            cli_plot[k]          = 1'b1;
            if (!cfg_hang[k] && i == cfg_npix[k] - 1) cli_done[k] = 1'b1;
            p.x = 8'(10 * k + i);
            p.y = 8'd5;
            p.c = 3'(k + 1);
            p.cyc = 32'(cyc);
            exp_q.push_back(p);
            if (rogue_en && k == 0) begin
                cli_plot[2]    = 1'b1;
                cli_x[23:16]   = 8'd200;
                cli_y[23:16]   = 8'd7;
                cli_colour[8:6] = 3'd7;
                cli_done[2]    = 1'b1;
            end
        end
        if (cfg_npix[k] == 0 && !cfg_hang[k]) begin
            @(negedge clock);
            cli_done[k] = 1'b1;
        end
        @(negedge clock);
        if (cfg_hang[k]) begin
            clear_cli();
            for (int n = 0; n < 300; n++) begin
                if (reset === 1'b1 || cli_start !== 3'b000 || busy !== 1'b1) break;
                @(negedge clock);
            end
        end
        clear_cli();
    endtask

    // Client model process.
    initial begin
        clear_cli();
        forever begin
            if (reset === 1'b0 && cli_start !== 3'b000 && !$isunknown(cli_start)) begin
                if (cli_start[0]) serve(0);
                else if (cli_start[1]) serve(1);
                else serve(2);
            end else begin
                @(negedge clock);
            end
        end
    end

    // Pixel monitor and scoreboard.
    initial begin
        pix_t e;
        forever begin
            @(negedge clock);
            if (reset === 1'b0 && plot === 1'b1) begin
                n_writes++;
                if (out_x === 8'd200) rogue_seen = 1'b1;
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL pixel_unexpected: got x=%0d y=%0d c=%0d, required no write",
                             out_x, out_y, colour);
                end else begin
                    e = exp_q.pop_front();
                    if ({out_x, out_y, colour} !== {e.x, e.y, e.c} || 32'(cyc) !== e.cyc + 1) begin
                        $display("FAIL pixel: got x=%0d y=%0d c=%0d cyc=%0d, required x=%0d y=%0d c=%0d cyc=%0d",
                                 out_x, out_y, colour, cyc, e.x, e.y, e.c, e.cyc + 1);
                    end else begin
                        n_pass++;
                    end
                end
            end
        end
    end

    task automatic wait_tick(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            if (frame_tick === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            if (busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        enable = 1'b0;
        clear_flags = 1'b0;
        o_enable = 1'b0;
        o_clear = 1'b0;
        o_done = 3'b000;
        for (int k = 0; k < 3; k++) begin
            cfg_npix[k] = 0;
            cfg_hang[k] = 1'b0;
        end
        repeat (3) @(negedge clock);
        n_checks++;
        if ({cli_start, out_x, out_y, colour, plot, frame_tick, busy, overrun, timeout_flags} !== 29'd0)
            $display("FAIL reset_outputs: got %h, required 0",
                     {cli_start, out_x, out_y, colour, plot, frame_tick, busy, overrun, timeout_flags});
        else n_pass++;
        n_checks++;
        if ({o_start, o_plot, o_tick, o_busy, o_overrun, o_tflags} !== 10'd0)
            $display("FAIL reset_outputs_ovr: got %h, required 0",
                     {o_start, o_plot, o_tick, o_busy, o_overrun, o_tflags});
        else n_pass++;
        reset = 1'b0;
        rel_cyc = cyc;
    endtask

    task automatic test_frame_timing();
        bit ok;
        int t0;
        enable = 1'b1;
        wait_tick(150, ok);
        n_checks++;
        if (!ok || cyc - rel_cyc != 100)
            $display("FAIL first_tick: got ok=%0d after %0d cycles, required 100", ok, cyc - rel_cyc);
        else n_pass++;
        t0 = cyc;
        @(negedge clock);
        n_checks++;
        if (cli_start !== 3'b001 || frame_tick !== 1'b0)
            $display("FAIL start_after_tick: got start=%b tick=%b, required 001/0", cli_start, frame_tick);
        else n_pass++;
        for (int r = 0; r < 2; r++) begin
            wait_tick(150, ok);
            n_checks++;
            if (!ok || cyc - t0 != 100)
                $display("FAIL tick_period: got ok=%0d period %0d, required 100", ok, cyc - t0);
            else n_pass++;
            t0 = cyc;
        end
        wait_idle(40, ok);
    endtask

    task automatic run_pass(input string name, input int exp_len, input int exp_writes);
        bit ok;
        int t0;
        wait_tick(150, ok);
        n_writes = 0;
        t0 = cyc;
        @(negedge clock);
        wait_idle(80, ok);
        n_checks++;
        if (!ok || cyc - t0 != exp_len)
            $display("FAIL %s_busy_fall: got ok=%0d at %0d cycles, required %0d", name, ok, cyc - t0, exp_len);
        else n_pass++;
        repeat (2) @(negedge clock);
        n_checks++;
        if (n_writes != exp_writes || exp_q.size() != 0)
            $display("FAIL %s_writes: got %0d writes, %0d pending, required %0d, 0", name, n_writes,
                     exp_q.size(), exp_writes);
        else n_pass++;
    endtask

    task automatic test_full_pass();
        for (int k = 0; k < 3; k++) cfg_npix[k] = 4;
        run_pass("full_pass", 16, 12);
    endtask

    task automatic test_rogue();
        rogue_seen = 1'b0;
        rogue_en = 1'b1;
        run_pass("rogue", 16, 12);
        rogue_en = 1'b0;
        n_checks++;
        if (rogue_seen !== 1'b0) $display("FAIL rogue_x200: got write to x=200, required none");
        else n_pass++;
    endtask

    task automatic test_hung();
        bit ok;
        int s;
        logic [2:0] prev_flags;
        cfg_npix[1] = 2;
        cfg_hang[1] = 1'b1;
        wait_tick(150, ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (cli_start === 3'b010) begin
                ok = 1'b1;
                break;
            end
        end
        s = cyc;
        prev_flags = 3'bxxx;
        for (int i = 0; i < 40; i++) begin
            prev_flags = timeout_flags;
            @(negedge clock);
            if (cli_start === 3'b100) break;
        end
        n_checks++;
        if (!ok || cli_start !== 3'b100 || cyc - s != 17)
            $display("FAIL hung_advance: got start=%b after %0d cycles, required 100 after 17",
                     cli_start, cyc - s);
        else n_pass++;
        n_checks++;
        if (prev_flags !== 3'b000 || timeout_flags !== 3'b010)
            $display("FAIL hung_flags: got %b then %b, required 000 then 010", prev_flags, timeout_flags);
        else n_pass++;
        wait_idle(40, ok);
        repeat (2) @(negedge clock);
        n_checks++;
        if (exp_q.size() != 0 || timeout_flags !== 3'b010)
            $display("FAIL hung_pass_end: got %0d pending flags=%b, required 0 and 010",
                     exp_q.size(), timeout_flags);
        else n_pass++;
        clear_flags = 1'b1;
        @(negedge clock);
        clear_flags = 1'b0;
        n_checks++;
        if (timeout_flags !== 3'b000)
            $display("FAIL hung_clear: got %b, required 000", timeout_flags);
        else n_pass++;
        cfg_hang[1] = 1'b0;
        cfg_npix[1] = 4;
    endtask

    task automatic test_enable();
        bit ok;
        int starts;
        bit saw2;
        enable = 1'b0;
        wait_tick(150, ok);
        starts = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (cli_start !== 3'b000 || busy !== 1'b0) starts++;
        end
        n_checks++;
        if (starts != 0) $display("FAIL enable_low_tick: got %0d active cycles, required 0", starts);
        else n_pass++;
        enable = 1'b1;
        wait_tick(150, ok);
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (cli_start === 3'b010) break;
        end
        enable = 1'b0;
        saw2 = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (cli_start === 3'b100) saw2 = 1'b1;
            if (busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!ok || !saw2) $display("FAIL enable_drop_completes: got idle=%0d saw2=%0d, required 1/1", ok, saw2);
        else n_pass++;
        wait_tick(150, ok);
        starts = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (cli_start !== 3'b000) starts++;
        end
        n_checks++;
        if (starts != 0) $display("FAIL enable_next_tick: got %0d starts, required 0", starts);
        else n_pass++;
        enable = 1'b1;
    endtask

    task automatic test_reset_mid();
        bit ok;
        int starts;
        cfg_npix[1] = 2;
        cfg_hang[1] = 1'b1;
        wait_tick(150, ok);
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (cli_start === 3'b010) break;
        end
        repeat (3) @(negedge clock);
        n_checks++;
        if (busy !== 1'b1) $display("FAIL reset_mid_busy: got %b, required 1", busy);
        else n_pass++;
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if ({cli_start, out_x, out_y, colour, plot, frame_tick, busy, overrun, timeout_flags} !== 29'd0)
            $display("FAIL reset_mid_outputs: got %h, required 0",
                     {cli_start, out_x, out_y, colour, plot, frame_tick, busy, overrun, timeout_flags});
        else n_pass++;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        rel_cyc = cyc;
        cfg_hang[1] = 1'b0;
        cfg_npix[1] = 4;
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL reset_mid_pending: got %0d, required 0", exp_q.size());
        else n_pass++;
        starts = 0;
        ok = 1'b0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clock);
            if (cli_start !== 3'b000) starts++;
            if (frame_tick === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!ok || starts != 0 || cyc - rel_cyc != 100)
            $display("FAIL reset_mid_quiet: got ok=%0d starts=%0d tick at %0d, required 1/0/100",
                     ok, starts, cyc - rel_cyc);
        else n_pass++;
        @(negedge clock);
        n_checks++;
        if (cli_start !== 3'b001) $display("FAIL reset_mid_restart: got %b, required 001", cli_start);
        else n_pass++;
        wait_idle(40, ok);
    endtask

    task automatic test_overrun();
        bit ok;
        bit saw_tick;
        bit seen2;
        logic ovr_before;
        int extra;
        enable = 1'b0;
        o_enable = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 250; i++) begin
            @(negedge clock);
            if (o_tick === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        @(negedge clock);
        n_checks++;
        if (!ok || o_start !== 3'b001) $display("FAIL ovr_start0: got ok=%0d start=%b, required 001", ok, o_start);
        else n_pass++;
        saw_tick = 1'b0;
        ovr_before = 1'b1;
        extra = 0;
        for (int i = 1; i < 150; i++) begin
            @(negedge clock);
            if (o_tick === 1'b1) saw_tick = 1'b1;
            else if (!saw_tick) ovr_before = o_overrun;
            if (o_start !== 3'b000) extra++;
            if (i == 149) o_done = 3'b001;
        end
        n_checks++;
        if (!saw_tick || ovr_before !== 1'b0 || extra != 0)
            $display("FAIL ovr_tick_dropped: got tick=%0d ovr_before=%b starts=%0d, required 1/0/0",
                     saw_tick, ovr_before, extra);
        else n_pass++;
        @(negedge clock);
        o_done = 3'b110;
        n_checks++;
        if (o_start !== 3'b010 || o_overrun !== 1'b1)
            $display("FAIL ovr_client1: got start=%b overrun=%b, required 010/1", o_start, o_overrun);
        else n_pass++;
        seen2 = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (o_start === 3'b100) seen2 = 1'b1;
            if (o_busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        o_done = 3'b000;
        n_checks++;
        if (!ok || !seen2 || o_tflags !== 3'b000)
            $display("FAIL ovr_finish: got idle=%0d seen2=%0d tflags=%b, required 1/1/000", ok, seen2, o_tflags);
        else n_pass++;
        o_clear = 1'b1;
        @(negedge clock);
        o_clear = 1'b0;
        o_enable = 1'b0;
        n_checks++;
        if (o_overrun !== 1'b0) $display("FAIL ovr_clear: got %b, required 0", o_overrun);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_frame_timing();
        test_full_pass();
        test_rogue();
        test_hung();
        test_enable();
        test_reset_mid();
        test_overrun();
        repeat (5) @(negedge clock);
        n_checks++;
        if (exp_q.size() != 0 || overrun !== 1'b0)
            $display("FAIL final: got %0d pending overrun=%b, required 0/0", exp_q.size(), overrun);
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
